// File: rtl/ram_1.sv
// Single-port flip-flop RAM, clearable by async reset; read latency 1 cycle.
// Write-through on read-during-write; no backpressure, accepts an access every cycle.
module ram_1 #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  wren,
  output logic [DATA_WIDTH-1:0] q
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]         idx;

  // Modulo decode keeps every address value legal even if DEPTH is not a power of two.
  assign idx = IW'(32'(address) % 32'(DEPTH));

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      q <= '0;
    end else begin
      if (wren) begin
        mem[idx] <= data;
      end
      q <= wren ? data : mem[idx];
    end
  end

endmodule

// File: tb/tb_ram_1.sv
// Scoreboard bench for ram_1: a reference memory model predicts q for every
// cycle, expectations are queued at drive time and popped one edge later.
module tb_ram_1;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] address;
  logic [7:0] data;
  logic       wren;
  logic [7:0] q;

  logic [7:0] model [64];
  logic [7:0] exp_q [$];
  int         n_checks = 0;
  int         n_errors = 0;

  ram_1 dut (
    .clock   (clk),
    .rst     (rst),
    .address (address),
    .data    (data),
    .wren    (wren),
    .q       (q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) model[i] = 8'h00;
  endtask

  // One access: drive on the falling edge, predict, then check after the rising edge.
  task automatic cycle(input string tag, input logic [5:0] a, input logic [7:0] d, input logic we);
    logic [7:0] e;
    @(negedge clk);
    address = a;
    data    = d;
    wren    = we;
    e = we ? d : model[a];
    if (we) model[a] = d;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 8'h01, 8'h00);
    end else begin
      check(tag, q, exp_q.pop_front());
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst     = 1'b1;
    address = '0;
    data    = '0;
    wren    = 1'b0;
    clear_model();

    // Reset asserted: q clears at once, writes ignored while held low.
    #2 rst = 1'b0;
    #1 check("reset_q_async", q, 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      address = 6'(i);
      data    = 8'hEE;
      wren    = 1'b1;
      @(posedge clk);
      #1 check("reset_held_q", q, 8'h00);
    end
    @(negedge clk);
    wren = 1'b0;
    #2 rst = 1'b1;

    for (int a = 0; a < 64; a++) cycle("reset_read", 6'(a), 8'h00, 1'b0);

    for (int a = 0; a < 64; a++) cycle("fill_write", 6'(a), 8'(a) ^ 8'hA5, 1'b1);
    for (int a = 0; a < 64; a++) cycle("fill_read", 6'(a), 8'h00, 1'b0);

    cycle("rdw_pre", 6'h10, 8'h33, 1'b1);
    cycle("rdw_pre_read", 6'h10, 8'h00, 1'b0);
    cycle("rdw_write", 6'h10, 8'hC3, 1'b1);
    cycle("rdw_read", 6'h10, 8'h00, 1'b0);

    for (int a = 0; a < 64; a++) cycle("protect_drive", 6'(a), 8'hFF, 1'b0);
    for (int a = 0; a < 64; a++) cycle("protect_read", 6'(a), 8'h00, 1'b0);

    cycle("wrap_w63", 6'd63, 8'h5A, 1'b1);
    cycle("wrap_w0", 6'd0, 8'h3C, 1'b1);
    cycle("wrap_r62", 6'd62, 8'h00, 1'b0);
    cycle("wrap_r1", 6'd1, 8'h00, 1'b0);
    cycle("wrap_r63", 6'd63, 8'h00, 1'b0);
    cycle("wrap_r0", 6'd0, 8'h00, 1'b0);

    // Mid-cycle reset: q must drop before the next rising edge, contents lost.
    @(negedge clk);
    #2 rst = 1'b0;
    #1 check("midop_reset_q", q, 8'h00);
    clear_model();
    @(negedge clk);
    #1 rst = 1'b1;
    cycle("post_reset_r0", 6'd0, 8'h00, 1'b0);
    cycle("post_reset_r31", 6'd31, 8'h00, 1'b0);
    cycle("post_reset_r63", 6'd63, 8'h00, 1'b0);
    cycle("post_reset_wr", 6'd31, 8'h81, 1'b1);
    cycle("post_reset_rd", 6'd31, 8'h00, 1'b0);

    check("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ram_1.md
RAM_1 -- requirements
Module: ram_1

Interface
REQ-001 Parameter DATA_WIDTH SHALL default to 8 and set the width of each memory word.
REQ-002 Parameter ADDR_WIDTH SHALL default to 6 and set the address width.
REQ-003 Parameter DEPTH SHALL default to 64 (2**ADDR_WIDTH) and set the number of words.
REQ-004 Port clock SHALL be an input, 1 bit: the single clock; all sampling is on its rising edge.
REQ-005 Port rst SHALL be an input, 1 bit: asynchronous, active-low reset.
REQ-006 Port address SHALL be an input, ADDR_WIDTH bits: word select shared by read and write.
REQ-007 Port data SHALL be an input, DATA_WIDTH bits: write data.
REQ-008 Port wren SHALL be an input, 1 bit: write enable, active-high.
REQ-009 Port q SHALL be an output, DATA_WIDTH bits: registered read data.

Function
REQ-010 Storage SHALL be DEPTH words of DATA_WIDTH bits, single port: one address for both read and write.
REQ-011 If wren=1 at a rising clock edge, the word at address SHALL take the value on data at that edge.
REQ-012 If wren=0 at a rising clock edge, no memory location SHALL change.
REQ-013 At every rising edge, q SHALL load the word selected by address at that edge; read latency is one cycle.
REQ-014 Read-during-write: when wren=1, q SHALL load the new data being written (write-through), never the old contents.
REQ-015 Between rising edges, q SHALL hold its value regardless of changes on address, data or wren.
REQ-016 Address SHALL be decoded modulo DEPTH; every value of address is a valid location; no out-of-range behaviour exists.
REQ-017 A write SHALL affect exactly one location; all other locations SHALL keep their contents.
REQ-018 If X/Z is present on wren at a rising edge, the behaviour is unspecified; the bench SHALL NOT rely on it.
REQ-019 Contents SHALL persist indefinitely while rst is high; there is no refresh or auto-clear.
REQ-020 Storage SHALL be built from flip-flops (no vendor macro), so that reset can clear it per REQ-021.

Reset
REQ-021 When rst goes low, q and all DEPTH memory words SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-022 While rst is low, writes SHALL be ignored and q SHALL stay 0.
REQ-023 After rst goes high, the first rising edge SHALL perform normal operation (write and/or read).
REQ-024 If rst is asserted mid-sequence (between or during write bursts), all previously written data SHALL be lost and read back as 0.
REQ-025 If rst is deasserted coincident with a rising edge, that edge SHALL be ignored; operation starts at the next edge.

Verification
REQ-026 Reset: drive rst=0, then release it; read all 64 addresses -> q=0x00 at every address, each with one cycle of latency.
REQ-027 Sequential fill: write data=addr^0xA5 to addresses 0..63 on consecutive edges with wren=1, then read 0..63 -> each q equals addr^0xA5, one cycle after its address is presented.
REQ-028 Read-during-write: with address=0x10 (holding 0x33), drive wren=1, data=0xC3 for one edge -> q=0xC3 after that edge; read 0x10 again -> q=0xC3.
REQ-029 Write-protect: with wren=0, drive data=0xFF across all addresses, then read back -> contents from REQ-027 are unchanged.
REQ-030 Async reset mid-operation: after the fill, pull rst low between clock edges -> q=0x00 before the next edge; after release, reading addresses 0, 31 and 63 returns 0x00.
REQ-031 Isolation/wrap: write 0x5A to address 63 and 0x3C to address 0 -> address 62 and address 1 are unchanged, and address 63 reads 0x5A.
